cdc_handshake_tx: RTL and testbench

Source-side controller for a 4-phase req/ack clock-domain-crossing bus.
- Accepts one word at a time on a valid/ready interface.
- Holds the word stable on cdc_data_o and sequences cdc_req_o against an asynchronous cdc_ack_i.
- Synchronises cdc_ack_i internally through a beat_it_twice instance (DATA_WIDTH=1).
- Supervises each handshake phase with a timeout counter and reports failures as a sticky error.

---
 rtl/cdc_handshake_tx.sv | 196 +++++++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain-crossing link.
// One word is taken on a valid/ready port, parked on cdc_data_o and announced with
// cdc_req_o. The far side echoes it on the asynchronous cdc_ack_i.
// Each wait on the far side is supervised by a timeout that raises a sticky error.

// Plain two-flop synchroniser for signals entering this clock domain.
module beat_it_twice #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] meta;

   // Two back-to-back flops, left unreset so they can sit right at the boundary.
   always_ff @(posedge clk) begin
      meta <= d;
      q    <= meta;
   end

endmodule

module cdc_handshake_tx #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_rst_n_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [DATA_WIDTH-1:0] cdc_data_o,
   output logic                  cdc_req_o,
   input  logic                  cdc_ack_i,
   output logic                  done_o,
   output logic                  err_o,
   input  logic                  err_clr_i,
   output logic                  busy_o
);

   // Upstream handshake: a word moves on any rising edge where s_valid_i and s_ready_o
   // are both high. s_ready_o is high only in IDLE. While s_ready_o is low, s_valid_i
   // is ignored and the upstream must hold its word unchanged until it is taken.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      REL   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Last counter value of a phase; reaching it with no exit condition is a timeout.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                state_q;
   state_t                state_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  req_q;
   logic                  req_d;
   logic                  done_q;
   logic                  done_d;
   logic                  err_q;
   logic                  err_d;
   logic                  ready_q;
   logic                  ready_d;
   logic                  busy_q;
   logic                  busy_d;
   logic                  ack_s;
   logic                  cnt_max;
   logic                  timeout;

   // Bring the far-side acknowledge into sys_clk_i; IDLE ignores it, so stale power-up values are harmless.
   beat_it_twice #(
      .DATA_WIDTH (1)
   ) u_ack_sync (
      .clk (sys_clk_i),
      .d   (cdc_ack_i),
      .q   (ack_s)
   );

   assign cnt_max = (cnt_q == CNT_LAST);

   // Next-state, counter and output logic; an exit condition always beats the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      req_d   = req_q;
      done_d  = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            req_d = 1'b0;
            if (s_valid_i && ready_q) begin
               data_d  = s_data_i;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = REL;
            end else if (cnt_max) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               timeout = 1'b1;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         REL: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_max) begin
               cnt_d   = '0;
               timeout = 1'b1;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DRAIN: begin
            // Request is already withdrawn; wait as long as it takes for ack to drop.
            req_d = 1'b0;
            cnt_d = '0;
            if (!ack_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error: a timeout on the same cycle as a clear still sets it.
   always_comb begin
      err_d = err_q;
      if (timeout) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   // Status flags are registered from the next state so they line up with the state register.
   always_comb begin
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   // State register and all registered outputs; reset pulls req low at once.
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign s_ready_o  = ready_q;
   assign cdc_data_o = data_q;
   assign cdc_req_o  = req_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a 16-cycle phase timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cdc_handshake_tx;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_data_i;
   logic          s_valid_i;
   logic          s_ready_o;
   logic [DW-1:0] cdc_data_o;
   logic          cdc_req_o;
   logic          cdc_ack_i;
   logic          done_o;
   logic          err_o;
   logic          err_clr_i;
   logic          busy_o;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int done_base;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_word;

   cdc_handshake_tx #(
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (16),
      .CNT_WIDTH      (16)
   ) dut (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .cdc_data_o  (cdc_data_o),
      .cdc_req_o   (cdc_req_o),
      .cdc_ack_i   (cdc_ack_i),
      .done_o      (done_o),
      .err_o       (err_o),
      .err_clr_i   (err_clr_i),
      .busy_o      (busy_o)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and note any done pulse seen there.
   task automatic tick();
      @(negedge clk);
      if (done_o === 1'b1) done_seen++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      s_data_i  = '0;
      s_valid_i = 1'b0;
      cdc_ack_i = 1'b0;
      err_clr_i = 1'b0;
      ticks(4);
      rst_n = 1'b1;
      tick();

      // Reset values
      chk("rst_ready", s_ready_o, 1);
      chk("rst_req", cdc_req_o, 0);
      chk("rst_data", cdc_data_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);

      // 1. Normal transfer
      done_base = done_seen;
      s_data_i  = 32'hDEADBEEF;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      s_data_i  = 32'h0;
      chk("t1_req_up", cdc_req_o, 1);
      chk("t1_data", cdc_data_o, 32'hDEADBEEF);
      chk("t1_ready_low", s_ready_o, 0);
      chk("t1_busy", busy_o, 1);
      ticks(3);
      chk("t1_data_hold", cdc_data_o, 32'hDEADBEEF);
      cdc_ack_i = 1'b1;
      ticks(2);
      chk("t1_req_sync", cdc_req_o, 1);
      tick();
      chk("t1_req_down", cdc_req_o, 0);
      chk("t1_busy_rel", busy_o, 1);
      ticks(3);
      cdc_ack_i = 1'b0;
      ticks(2);
      chk("t1_not_done_yet", done_o, 0);
      tick();
      chk("t1_done", done_o, 1);
      chk("t1_ready_back", s_ready_o, 1);
      chk("t1_idle", busy_o, 0);
      tick();
      chk("t1_done_pulse", done_o, 0);
      chk("t1_done_count", done_seen - done_base, 1);
      chk("t1_err", err_o, 0);

      // 2. Back-to-back words with s_valid_i held high
      done_base = done_seen;
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd2);
      exp_q.push_back(32'd3);
      s_data_i  = 32'd1;
      s_valid_i = 1'b1;
      for (int w = 1; w <= 3; w++) begin
         tick();
         exp_word = exp_q.pop_front();
         chk("t2_req_up", cdc_req_o, 1);
         chk("t2_data", cdc_data_o, exp_word);
         if (w < 3) s_data_i = DW'(w + 1);
         else s_valid_i = 1'b0;
         cdc_ack_i = 1'b1;
         ticks(3);
         chk("t2_req_down", cdc_req_o, 0);
         chk("t2_data_rel", cdc_data_o, exp_word);
         cdc_ack_i = 1'b0;
         ticks(3);
         chk("t2_done", done_o, 1);
         chk("t2_ready", s_ready_o, 1);
         chk("t2_data_done", cdc_data_o, exp_word);
      end
      tick();
      chk("t2_idle", busy_o, 0);
      chk("t2_no_extra_req", cdc_req_o, 0);
      chk("t2_done_count", done_seen - done_base, 3);

      // 3. REQ timeout
      done_base = done_seen;
      s_data_i  = 32'hA5A5_0003;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      ticks(15);
      chk("t3_req_before_to", cdc_req_o, 1);
      chk("t3_err_before_to", err_o, 0);
      tick();
      chk("t3_req_to", cdc_req_o, 0);
      chk("t3_err_set", err_o, 1);
      chk("t3_drain_busy", busy_o, 1);
      chk("t3_data_drain", cdc_data_o, 32'hA5A5_0003);
      tick();
      chk("t3_idle", busy_o, 0);
      chk("t3_ready", s_ready_o, 1);
      chk("t3_err_sticky", err_o, 1);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("t3_err_clr", err_o, 0);
      chk("t3_no_done", done_seen - done_base, 0);

      // 4. REL timeout with ack stuck high
      done_base = done_seen;
      s_data_i  = 32'h0000_0004;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      cdc_ack_i = 1'b1;
      ticks(3);
      chk("t4_req_down", cdc_req_o, 0);
      ticks(15);
      chk("t4_err_before_to", err_o, 0);
      tick();
      chk("t4_err_set", err_o, 1);
      chk("t4_busy_drain", busy_o, 1);
      ticks(3);
      chk("t4_drain_holds", busy_o, 1);
      chk("t4_ready_low", s_ready_o, 0);
      cdc_ack_i = 1'b0;
      ticks(2);
      chk("t4_drain_sync", busy_o, 1);
      tick();
      chk("t4_idle", busy_o, 0);
      chk("t4_no_done", done_seen - done_base, 0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("t4_err_clr", err_o, 0);

      // 5a. ack_s arrives exactly on the last REQ counter value
      done_base = done_seen;
      s_data_i  = 32'h0000_0005;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      ticks(13);
      cdc_ack_i = 1'b1;
      ticks(2);
      chk("t5_req_last", cdc_req_o, 1);
      tick();
      chk("t5_req_down", cdc_req_o, 0);
      chk("t5_no_err", err_o, 0);
      chk("t5_rel_busy", busy_o, 1);
      cdc_ack_i = 1'b0;
      ticks(3);
      chk("t5_done", done_o, 1);
      chk("t5_err_still0", err_o, 0);
      chk("t5_done_count", done_seen - done_base, 1);

      // 5b. Timeout and err_clr_i on the same cycle: set wins
      tick();
      s_data_i  = 32'h0000_0055;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      ticks(15);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("t5_set_wins", err_o, 1);
      chk("t5_req_to", cdc_req_o, 0);
      tick();
      chk("t5_idle", busy_o, 0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("t5_err_clr", err_o, 0);

      // 6. Asynchronous reset while in REQ
      s_data_i  = 32'h0000_0066;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      ticks(3);
      chk("t6_req_before", cdc_req_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_req_async", cdc_req_o, 0);
      chk("t6_data_async", cdc_data_o, 0);
      chk("t6_ready_async", s_ready_o, 1);
      chk("t6_busy_async", busy_o, 0);
      ticks(2);
      rst_n = 1'b1;
      tick();
      chk("t6_req_rel", cdc_req_o, 0);
      chk("t6_err_rel", err_o, 0);
      chk("t6_ready_rel", s_ready_o, 1);
      done_base = done_seen;
      s_data_i  = 32'h1234_5678;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
      chk("t6_req_up", cdc_req_o, 1);
      chk("t6_data", cdc_data_o, 32'h1234_5678);
      cdc_ack_i = 1'b1;
      ticks(3);
      chk("t6_req_down", cdc_req_o, 0);
      cdc_ack_i = 1'b0;
      ticks(3);
      chk("t6_done", done_o, 1);
      chk("t6_done_count", done_seen - done_base, 1);
      chk("t6_err", err_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
